// File: rtl/result_drain_fifo.sv
// Row-to-chunk drain buffer: queues COLS-wide result rows and streams them out LANES columns at a time.
// Optional read-side ReLU on every output lane when RESULT_DRAIN_RELU_EN is defined.
module result_drain_fifo #(
    parameter int COLS       = 4,
    parameter int P_BITWIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int LANES      = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              in_valid,
    input  logic [COLS*P_BITWIDTH-1:0]        in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*P_BITWIDTH-1:0]       out_data,
    output logic                              out_last,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              overflow
);

    localparam int NCH   = COLS / LANES;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int K_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ROW_W = COLS * P_BITWIDTH;

    typedef enum logic {S_EMPTY, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               ovf_q, ovf_d;
    logic [ROW_W-1:0]   mem_q [DEPTH];

    logic               chunk_last, xfer, pop, push;
    logic [ROW_W-1:0]   head_row;
    logic signed [P_BITWIDTH-1:0] lane_val;

`ifdef RESULT_DRAIN_RELU_EN
    function automatic logic signed [P_BITWIDTH-1:0] relu(input logic signed [P_BITWIDTH-1:0] v);
        return v[P_BITWIDTH-1] ? '0 : v;
    endfunction
`endif

    assign chunk_last = (k_q == K_W'(NCH - 1));
    assign xfer       = out_valid && out_ready;
    assign pop        = xfer && chunk_last;
    // A full queue still accepts a row when the head row leaves on the same edge.
    assign push       = in_valid && !clear && ((count_q < CNT_W'(DEPTH)) || pop);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            k_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            k_q      <= k_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Pointer, occupancy, chunk-index and overflow next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        k_d      = k_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            k_d      = '0;
            ovf_d    = 1'b0;
        end else begin
            if (xfer) begin
                k_d = chunk_last ? '0 : k_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            if (in_valid && !push) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Next-state logic: DRAIN exactly while rows remain after this edge
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_EMPTY;
        end else if (count_d != '0) begin
            state_d = S_DRAIN;
        end else begin
            state_d = S_EMPTY;
        end
    end

    assign head_row = mem_q[rd_ptr_q];

    // Output logic, purely from registered state
    always_comb begin
        out_valid = (state_q == S_DRAIN);
        out_last  = out_valid && chunk_last;
        out_data  = '0;
        lane_val  = '0;
        if (out_valid) begin
            for (int l = 0; l < LANES; l++) begin
                lane_val = head_row[(int'(k_q) * LANES + l) * P_BITWIDTH +: P_BITWIDTH];
`ifdef RESULT_DRAIN_RELU_EN
                out_data[l*P_BITWIDTH +: P_BITWIDTH] = relu(lane_val);
`else
                out_data[l*P_BITWIDTH +: P_BITWIDTH] = lane_val;
`endif
            end
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_result_drain_fifo.sv
// Scoreboard bench for result_drain_fifo: stimulus enqueues expected chunks, a monitor checks them.
module tb_result_drain_fifo;

    localparam int COLS  = 4;
    localparam int PW    = 32;
    localparam int DEPTH = 8;
    localparam int LANES = 2;
    localparam int NCH   = COLS / LANES;
    localparam int ROWW  = COLS * PW;
    localparam int LW    = LANES * PW;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic [ROWW-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [LW-1:0]   out_data;
    logic            out_last;
    logic [CW-1:0]   count;
    logic            overflow;

    result_drain_fifo #(.COLS(COLS), .P_BITWIDTH(PW), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] data;
        logic          last;
    } chunk_t;

    chunk_t exp_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     mcount = 0;
    int     mk = 0;
    logic   movf = 1'b0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] chunk_of(input logic [ROWW-1:0] row, input int k);
        logic [LW-1:0]   c;
        logic [PW-1:0]   v;
        c = '0;
        for (int l = 0; l < LANES; l++) begin
            v = row[(k * LANES + l) * PW +: PW];
`ifdef RESULT_DRAIN_RELU_EN
            if (v[PW-1]) v = '0;
`endif
            c[l*PW +: PW] = v;
        end
        return c;
    endfunction

    function automatic logic [ROWW-1:0] rand_row();
        logic [ROWW-1:0] r;
        for (int c = 0; c < COLS; c++) r[c*PW +: PW] = $urandom;
        return r;
    endfunction

    // One clock of stimulus plus the reference-model update; entered and left at posedge+1.
    task automatic step(input logic iv, input logic [ROWW-1:0] d, input logic clr, input logic ordy);
        logic ev, xf, pp, acc;
        chunk_t ch;
        chk("count", count, mcount);
        chk("overflow", overflow, movf);
        chk("out_valid", out_valid, mcount > 0);
        in_valid  = iv;
        in_data   = d;
        clear     = clr;
        out_ready = clr ? 1'b0 : ordy;
        ev = mcount > 0;
        xf = ev && out_ready;
        pp = xf && (mk == NCH - 1);
        if (clr) begin
            mcount = 0;
            mk     = 0;
            movf   = 1'b0;
            exp_q.delete();
        end else begin
            if (xf) mk = pp ? 0 : mk + 1;
            acc = iv && (mcount < DEPTH || pp);
            if (iv && !acc) movf = 1'b1;
            if (acc) begin
                for (int k = 0; k < NCH; k++) begin
                    ch.data = chunk_of(d, k);
                    ch.last = (k == NCH - 1);
                    exp_q.push_back(ch);
                end
            end
            mcount = mcount + int'(acc) - int'(pp);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever a chunk is presented it must be the oldest outstanding expected chunk.
    always @(negedge clk) begin
        if (!rst && !clear && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_chunk", {127'd0, out_valid}, 128'd0);
            end else begin
                chk("chunk_data", out_data, exp_q[0].data);
                chk("chunk_last", out_last, exp_q[0].last);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    logic [ROWW-1:0] r1;
    logic [LW-1:0]   e1, e2;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;

        // Single known row
        r1 = '0;
        r1[0*PW +: PW] = 32'd1;
        r1[1*PW +: PW] = 32'hFFFF_FFFE;
        r1[2*PW +: PW] = 32'd3;
        r1[3*PW +: PW] = 32'd4;
        e1 = '0;
        e1[31:0] = 32'd1;
`ifdef RESULT_DRAIN_RELU_EN
        e1[63:32] = 32'd0;
`else
        e1[63:32] = 32'hFFFF_FFFE;
`endif
        e2 = {32'd4, 32'd3};
        step(1'b1, r1, 1'b0, 1'b1);
        chk("t1_chunk0", out_data, e1);
        chk("t1_last0", out_last, 0);
        chk("t1_count1", count, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t1_chunk1", out_data, e2);
        chk("t1_last1", out_last, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t1_valid_fall", out_valid, 0);
        chk("t1_count0", count, 0);

        // Fill to capacity, then overflow
        for (int i = 0; i < DEPTH; i++) step(1'b1, rand_row(), 1'b0, 1'b0);
        chk("t2_full_count", count, DEPTH);
        chk("t2_no_ovf", overflow, 0);
        step(1'b1, rand_row(), 1'b0, 1'b0);
        chk("t2_ovf_count", count, DEPTH);
        chk("t2_ovf", overflow, 1);
        for (int i = 0; i < DEPTH * NCH + 1; i++) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Push into a full queue on the head row's final handshake
        for (int i = 0; i < DEPTH; i++) step(1'b1, rand_row(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, rand_row(), 1'b0, 1'b1);
        chk("t3_count", count, DEPTH);
        chk("t3_ovf", overflow, 0);

        // Overflow again, then drain with a stalling consumer
        step(1'b1, rand_row(), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, (i % 4 == 0) || (i % 4 == 3));
        chk("t4_count", count, 5);
        chk("t4_ovf", overflow, 1);

        // Clear beats a simultaneous push
        step(1'b1, rand_row(), 1'b1, 1'b0);
        chk("t5_count", count, 0);
        chk("t5_ovf", overflow, 0);
        chk("t5_valid", out_valid, 0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a row
        step(1'b1, rand_row(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_last", out_last, 0);
        chk("t6_data", out_data, 0);
        chk("t6_count", count, 0);
        chk("t6_ovf", overflow, 0);
        mcount = 0;
        mk     = 0;
        movf   = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, rand_row(), 1'b0, 1'b1);
        for (int i = 0; i < NCH + 1; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 4, rand_row(), $urandom_range(0, 63) == 0,
                 $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < DEPTH * NCH + 4; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk("final_drained", exp_q.size(), 0);
        chk("final_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_drain_fifo.md
# result_drain_fifo

Output-side buffer for the systolic-array CNN accelerator: captures each `COLS`-wide partial-sum row the array presents on its `result` bus when `ready` pulses, queues up to `DEPTH` rows, and drains them as `LANES`-wide chunks over a valid/ready handshake. It sits between the datapath's systolic array and the output writeback path. It generalises the single-row `result`/`ready` output to a parametrised, back-pressured, multi-row stream with overflow detection.

## Interface
- `COLS`, 4, array columns per result row (same as `sys_cols`)
- `P_BITWIDTH`, 32, signed partial-sum width per column
- `DEPTH`, 8, rows of storage; power of two, ≥2
- `LANES`, 2, columns per output chunk; `COLS % LANES == 0`
- `clk  input  1  clock, all state on rising edge`
- `rst  input  1  asynchronous, active-high reset`
- `clear  input  1  synchronous flush: empties queue, clears overflow`
- `in_valid  input  1  row strobe from array (`ready`); no back-pressure possible`
- `in_data  input  COLS*P_BITWIDTH  row; column c at bits [c*P_BITWIDTH +: P_BITWIDTH]`
- `out_valid  output  1  chunk available`
- `out_ready  input  1  consumer accepts chunk`
- `out_data  output  LANES*P_BITWIDTH  current chunk, lane 0 = lowest column of chunk`
- `out_last  output  1  current chunk is the final chunk of its row`
- `count  output  $clog2(DEPTH+1)  rows stored (a partially drained row counts)`
- `overflow  output  1  sticky: a row was dropped`

## Operation
- Storage: circular buffer of `DEPTH` rows, write pointer, read pointer, occupancy counter; pointers wrap modulo `DEPTH`.
- Read side: chunk index `k` in 0..`COLS/LANES-1`; `out_data` = columns `k*LANES .. k*LANES+LANES-1` of head row.
- Drain FSM, two states: EMPTY (`out_valid`=0) and DRAIN (`out_valid`=1). EMPTY→DRAIN when `count` becomes nonzero; DRAIN→EMPTY when last chunk of last stored row handshakes with no simultaneous push.
- Handshake: transfer when `out_valid && out_ready`; `k` increments; on `out_last` transfer `k` returns to 0 and head row pops.
- While `out_valid && !out_ready`, `out_data`/`out_last` hold stable.
- Push: `in_valid` writes row at write pointer if `count < DEPTH`, or if `count == DEPTH` and the head row pops in the same cycle.
- Full and no pop: row dropped, no state changes except `overflow` ← 1.
- Empty with push: row written; not visible on output until next cycle (no fall-through).
- Simultaneous push and pop: `count` unchanged, both pointers advance.
- `clear` has priority over push and pop in the same cycle: pointers, `count`, `k` → 0, `overflow` → 0, incoming row discarded.
- `overflow` cleared only by `rst` or `clear`.
- Data passed unmodified (signed, `P_BITWIDTH` bits) unless the configuration feature is enabled.

## Timing
- Reset values: `out_valid`=0, `out_last`=0 (`COLS==LANES` case: 1 only when valid), `out_data`=0, `count`=0, `overflow`=0; FSM in EMPTY, `k`=0, pointers 0.
- Reset asynchronous assertion takes effect immediately, mid-drain included; storage contents undefined but unobservable.
- Push-to-output latency: row pushed on edge N → `out_valid`=1 and first chunk on `out_data` after edge N, sampled at edge N+1.
- Throughput: one chunk per cycle with `out_ready` held high; a row drains in `COLS/LANES` cycles.
- `count` updates on the same edge as the push/pop that changes it.
- `out_data`, `out_last` are combinational from registered state (pointer, `k`, storage, FSM); no combinational path from `out_ready` or `in_valid` to any output.

## Configuration
- Macro `RESULT_DRAIN_RELU_EN`.
- Defined: each lane of `out_data` passes through ReLU: negative (MSB=1) values output as 0, non-negative unchanged; applied on the read side, stored data untouched.
- Undefined: `out_data` is the raw stored partial sum; no ReLU logic present.

## Test plan
- Reset then single row {c0=1,c1=-2,c2=3,c3=4} pushed, `out_ready`=1 → chunks {1,-2} (`out_last`=0) then {3,4} (`out_last`=1), `count` 1→0, `out_valid` falls after second chunk; with `RESULT_DRAIN_RELU_EN` first chunk reads {1,0}.
- Push 8 rows with `out_ready`=0 → `count`=8, `overflow`=0; 9th push → `count`=8, `overflow`=1; drain returns rows 1..8 in order, 9th absent.
- Full queue, push on the cycle of head row's `out_last` handshake → row accepted, `count` stays 8, `overflow`=0.
- `out_ready` toggled 1,0,0,1 during drain → `out_data` holds stable across stall cycles, no chunk duplicated or lost.
- `clear` asserted with `count`=5, `overflow`=1 and `in_valid`=1 same cycle → next cycle `count`=0, `overflow`=0, `out_valid`=0, new row not stored.
- `rst` asserted mid-row (after first chunk) → outputs at reset values immediately; post-reset push drains from chunk 0.
